// File: rtl/issue_queue_sched_pkg.sv
// Shared definitions for the fetch/decode issue queue: bus widths, RV32 opcodes,
// the queue entry layout and a small popcount helper.
package issue_queue_sched_pkg;

    localparam int PC_BUS    = 32;
    localparam int INST_BUS  = 32;
    localparam int ISQ_DEPTH = 8;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef struct packed {
        logic [PC_BUS-1:0]   pc;
        logic [INST_BUS-1:0] inst;
    } entry_t;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[1]} + {1'b0, m[0]};
    endfunction

endpackage

// File: rtl/issue_queue_sched_pair_check.sv
// Combinational dual-issue legality check for two consecutive instructions.
module pair_check
    import issue_queue_sched_pkg::*;
(
    input  logic [INST_BUS-1:0] inst0,
    input  logic [INST_BUS-1:0] inst1,
    output logic                pair_ok
);

    logic [6:0] opc0, opc1;
    logic [4:0] rd0, rs1_1, rs2_1;
    logic       wr0, rd_rs1, rd_rs2, raw, mem0, mem1, ctl0, serial;

    assign opc0  = inst0[6:0];
    assign opc1  = inst1[6:0];
    assign rd0   = inst0[11:7];
    assign rs1_1 = inst1[19:15];
    assign rs2_1 = inst1[24:20];

    always_comb begin
        wr0 = 1'b0;
        unique case (opc0)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OPIMM, OPC_OP, OPC_SYSTEM: wr0 = (rd0 != 5'd0);
            default: wr0 = 1'b0;
        endcase

        rd_rs1 = 1'b0;
        unique case (opc1)
            OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: rd_rs1 = 1'b1;
            default: rd_rs1 = 1'b0;
        endcase

        rd_rs2 = 1'b0;
        unique case (opc1)
            OPC_BRANCH, OPC_STORE, OPC_OP: rd_rs2 = 1'b1;
            default: rd_rs2 = 1'b0;
        endcase
    end

    assign raw    = wr0 && ((rd_rs1 && (rs1_1 == rd0)) || (rd_rs2 && (rs2_1 == rd0)));
    assign mem0   = (opc0 == OPC_LOAD) || (opc0 == OPC_STORE);
    assign mem1   = (opc1 == OPC_LOAD) || (opc1 == OPC_STORE);
    assign ctl0   = (opc0 == OPC_BRANCH) || (opc0 == OPC_JAL) || (opc0 == OPC_JALR);
    assign serial = (opc0 == OPC_SYSTEM) || (opc0 == OPC_FENCE) ||
                    (opc1 == OPC_SYSTEM) || (opc1 == OPC_FENCE);

    assign pair_ok = !(raw || (mem0 && mem1) || ctl0 || serial);

endmodule

// File: rtl/issue_queue_sched.sv
// Fetch-to-decode decoupling queue with in-order dual issue; the pair check
// decides whether the second head entry may issue alongside the first.
module issue_queue_sched
    import issue_queue_sched_pkg::*;
#(
    parameter int DEPTH = ISQ_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fq_valid,
    output logic                fq_ready,
    input  logic [1:0]          fq_mask,
    input  logic [PC_BUS-1:0]   fq_pc0,
    input  logic [INST_BUS-1:0] fq_inst0,
    input  logic [PC_BUS-1:0]   fq_pc1,
    input  logic [INST_BUS-1:0] fq_inst1,
    input  logic                id_stall,
    output logic [1:0]          id_valid,
    output logic [PC_BUS-1:0]   id_pc0,
    output logic [INST_BUS-1:0] id_inst0,
    output logic [PC_BUS-1:0]   id_pc1,
    output logic [INST_BUS-1:0] id_inst1,
    input  logic                flush
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          q_mem [DEPTH];
    logic [AW-1:0]   head, tail, head_p1, tail_p1;
    logic [CW-1:0]   count;
    logic            pair_ok, kill, enq, slot0, slot1;
    logic [1:0]      enq_n, deq_n;
    entry_t          e0, e1, h0, h1;

    assign head_p1 = head + AW'(1);
    assign tail_p1 = tail + AW'(1);
    assign h0      = q_mem[head];
    assign h1      = q_mem[head_p1];
    assign e0      = '{pc: fq_pc0, inst: fq_inst0};
    assign e1      = '{pc: fq_pc1, inst: fq_inst1};

    pair_check u_pair_check (
        .inst0   (h0.inst),
        .inst1   (h1.inst),
        .pair_ok (pair_ok)
    );

    assign kill     = rst || flush;
    assign fq_ready = (count <= CW'(DEPTH - 2));
    assign enq      = fq_valid && fq_ready && !flush;
    assign enq_n    = enq ? popcount2(fq_mask) : 2'd0;
    assign deq_n    = id_stall ? 2'd0 : popcount2(id_valid);

    // Invalid slots present zero so decode never sees stale entry contents.
    always_comb begin
        slot0    = !kill && (count >= CW'(1));
        slot1    = slot0 && (count >= CW'(2)) && pair_ok;
        id_valid = {slot0, slot1};
        id_pc0   = slot0 ? h0.pc   : '0;
        id_inst0 = slot0 ? h0.inst : '0;
        id_pc1   = slot1 ? h1.pc   : '0;
        id_inst1 = slot1 ? h1.inst : '0;
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= count + CW'(enq_n) - CW'(deq_n);
            head  <= head + AW'(deq_n);
            tail  <= tail + AW'(enq_n);
        end
    end

    // Valid lanes are packed in program order starting at the tail.
    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            case (fq_mask)
                2'b11: begin
                    q_mem[tail]    <= e0;
                    q_mem[tail_p1] <= e1;
                end
                2'b10:   q_mem[tail] <= e0;
                2'b01:   q_mem[tail] <= e1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_queue_sched.sv
// Self-checking bench for issue_queue_sched: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_issue_queue_sched;
    import issue_queue_sched_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, fq_valid, id_stall, flush;
    logic        fq_ready;
    logic [1:0]  fq_mask, id_valid;
    logic [31:0] fq_pc0, fq_inst0, fq_pc1, fq_inst1;
    logic [31:0] id_pc0, id_inst0, id_pc1, id_inst1;

    int tests_run = 0;
    int tests_failed = 0;

    entry_t model_q[$];

    issue_queue_sched #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .fq_valid(fq_valid), .fq_ready(fq_ready), .fq_mask(fq_mask),
        .fq_pc0(fq_pc0), .fq_inst0(fq_inst0), .fq_pc1(fq_pc1), .fq_inst1(fq_inst1),
        .id_stall(id_stall), .id_valid(id_valid),
        .id_pc0(id_pc0), .id_inst0(id_inst0), .id_pc1(id_pc1), .id_inst1(id_inst1),
        .flush(flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        logic [11:0] i12 = 12'(imm);
        return {i12, 5'(rs1), 3'b000, 5'(rd), OPC_OPIMM};
    endfunction

    function automatic logic [31:0] add(int rd, int rs1, int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), OPC_OP};
    endfunction

    // Reference pairing rules, phrased as "which register does it produce / which does it consume".
    function automatic int dest_of(logic [31:0] inst);
        logic [6:0] o = inst[6:0];
        if (o == OPC_LUI || o == OPC_AUIPC || o == OPC_JAL || o == OPC_JALR ||
            o == OPC_LOAD || o == OPC_OPIMM || o == OPC_OP || o == OPC_SYSTEM)
            return int'(inst[11:7]);
        return 0;
    endfunction

    function automatic bit consumes(logic [31:0] inst, int r);
        logic [6:0] o = inst[6:0];
        bit u1 = (o == OPC_JALR || o == OPC_BRANCH || o == OPC_LOAD ||
                  o == OPC_STORE || o == OPC_OPIMM || o == OPC_OP);
        bit u2 = (o == OPC_BRANCH || o == OPC_STORE || o == OPC_OP);
        return (u1 && int'(inst[19:15]) == r) || (u2 && int'(inst[24:20]) == r);
    endfunction

    function automatic bit model_pairable(logic [31:0] a, logic [31:0] b);
        int d = dest_of(a);
        bit mem_a = (a[6:0] == OPC_LOAD || a[6:0] == OPC_STORE);
        bit mem_b = (b[6:0] == OPC_LOAD || b[6:0] == OPC_STORE);
        if (d != 0 && consumes(b, d)) return 0;
        if (mem_a && mem_b) return 0;
        if (a[6:0] == OPC_BRANCH || a[6:0] == OPC_JAL || a[6:0] == OPC_JALR) return 0;
        if (a[6:0] == OPC_SYSTEM || a[6:0] == OPC_FENCE ||
            b[6:0] == OPC_SYSTEM || b[6:0] == OPC_FENCE) return 0;
        return 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, checks outputs mid-cycle, then advances the model at the edge.
    task automatic applyStimulus(input bit v, input logic [1:0] m,
                                 input logic [31:0] p0, input logic [31:0] i0,
                                 input logic [31:0] p1, input logic [31:0] i1,
                                 input bit stall, input bit fl, input bit do_check);
        int n;
        bit s0, s1, ready;
        fq_valid = v; fq_mask = m; fq_pc0 = p0; fq_inst0 = i0; fq_pc1 = p1; fq_inst1 = i1;
        id_stall = stall; flush = fl;
        @(negedge clk);
        n     = model_q.size();
        ready = (DEPTH - n) >= 2;
        s0    = !(fl || rst) && n >= 1;
        s1    = s0 && n >= 2 && model_pairable(model_q[0].inst, model_q[1].inst);
        if (do_check) begin
            checkOutput("fq_ready", 32'(fq_ready), 32'(ready));
            checkOutput("id_valid", 32'(id_valid), {30'd0, s0, s1});
            checkOutput("id_pc0",   id_pc0,   s0 ? model_q[0].pc   : 32'd0);
            checkOutput("id_inst0", id_inst0, s0 ? model_q[0].inst : 32'd0);
            checkOutput("id_pc1",   id_pc1,   s1 ? model_q[1].pc   : 32'd0);
            checkOutput("id_inst1", id_inst1, s1 ? model_q[1].inst : 32'd0);
        end
        if (fl || rst) begin
            model_q.delete();
        end else begin
            if (!stall) begin
                if (s0) void'(model_q.pop_front());
                if (s1) void'(model_q.pop_front());
            end
            if (v && ready) begin
                if (m[1]) model_q.push_back('{pc: p0, inst: i0});
                if (m[0]) model_q.push_back('{pc: p1, inst: i1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit stall, input int cycles);
        for (int k = 0; k < cycles; k++)
            applyStimulus(0, 2'b00, 0, 0, 0, 0, stall, 0, 1);
    endtask

    task automatic pushPair(input logic [31:0] pc, input logic [1:0] m,
                            input logic [31:0] i0, input logic [31:0] i1, input bit stall);
        applyStimulus(1, m, pc, i0, pc + 4, i1, stall, 0, 1);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] opcs [11] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                                  OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM, OPC_FENCE};
        logic [31:0] w = $urandom;
        int sel = $urandom_range(0, 20);
        w[6:0]   = (sel < 11) ? opcs[sel] : ((sel < 16) ? OPC_OPIMM : OPC_OP);
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        logic [31:0] pc;
        rst = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        idle(0, 1);

        $display("[TB] independent pair dual-issues");
        pushPair(32'h100, 2'b11, addi(1, 0, 1), addi(2, 0, 2), 0);
        idle(0, 2);

        $display("[TB] RAW hazard splits the pair");
        pushPair(32'h108, 2'b11, addi(1, 0, 1), add(3, 1, 1), 0);
        idle(0, 3);

        $display("[TB] memory pair and branch-first pair");
        pushPair(32'h110, 2'b11, {12'd0, 5'd2, 3'b010, 5'd5, OPC_LOAD},
                 {7'd0, 5'd6, 5'd2, 3'b010, 5'd4, OPC_STORE}, 0);
        idle(0, 3);
        pushPair(32'h118, 2'b11, {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, OPC_BRANCH}, addi(4, 0, 4), 0);
        idle(0, 3);

        $display("[TB] fill under stall, hold pair, drain across wrap");
        pc = 32'h200;
        for (int k = 0; k < 3; k++) begin
            pushPair(pc, 2'b11, addi(k + 1, 0, k), addi(k + 5, 0, k), 1);
            pc += 8;
        end
        pushPair(pc, 2'b10, addi(9, 0, 9), addi(10, 0, 10), 1);
        pc += 8;
        pushPair(pc, 2'b11, addi(11, 0, 1), addi(12, 0, 2), 1);
        pushPair(pc, 2'b11, addi(11, 0, 1), addi(12, 0, 2), 1);
        idle(0, 6);

        $display("[TB] flush with concurrent enqueue");
        pushPair(32'h300, 2'b11, addi(1, 0, 1), addi(2, 0, 2), 1);
        pushPair(32'h308, 2'b11, addi(3, 0, 1), addi(4, 0, 2), 1);
        pushPair(32'h310, 2'b10, addi(5, 0, 1), addi(6, 0, 2), 1);
        applyStimulus(1, 2'b11, 32'h318, addi(7, 0, 1), 32'h31c, addi(8, 0, 1), 0, 1, 1);
        idle(0, 2);

        $display("[TB] second-lane-only fetch and x0 destination");
        applyStimulus(1, 2'b01, 32'h100, addi(1, 0, 1), 32'h104, addi(2, 0, 2), 0, 0, 1);
        idle(0, 1);
        pushPair(32'h108, 2'b11, addi(0, 0, 1), add(3, 0, 0), 0);
        idle(0, 2);

        $display("[TB] random traffic");
        pc = 32'h1000;
        for (int k = 0; k < 400; k++) begin
            logic [1:0] m = 2'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 3) != 0, m, pc, rand_inst(), pc + 4, rand_inst(),
                          $urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0, 1);
            pc += 8;
        end

        rst = 1'b1;
        pushPair(32'h2000, 2'b11, addi(1, 0, 1), addi(2, 0, 2), 0);
        rst = 1'b0;
        idle(0, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
